trig_conditioner: RTL

Upstream front-end for `pulse_gen`. It takes the raw, asynchronous external trigger and produces the clean `pulse_in` that `pulse_gen` measures and reacts to. Processing steps:
- synchronise the trigger into `clk`;
- reject glitches;
- clamp the pulse width to a programmable minimum and maximum;
- enforce a re-trigger hold-off;
- report accepted, dropped and clamped triggers.

---
 rtl/trig_conditioner.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/trig_conditioner.sv
// Trigger front-end: synchronises and glitch-filters an async trigger, then clamps width,
// enforces hold-off and reports accepted / dropped / clamped events for pulse_gen.
module trig_conditioner #(
    parameter int BIT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trig_in,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] filt_len,
    input  logic [BIT_WIDTH-1:0] min_width,
    input  logic [BIT_WIDTH-1:0] max_width,
    input  logic [BIT_WIDTH-1:0] holdoff,
    output logic                 pulse_out,
    output logic                 busy,
    output logic                 err_short,
    output logic                 err_long,
    output logic                 drop,
    output logic [BIT_WIDTH-1:0] trig_count
);

    typedef enum logic [2:0] {IDLE, HIGH, STRETCH, WAIT_LOW, HOLDOFF} state_t;

    function automatic logic [BIT_WIDTH-1:0] sat_inc(input logic [BIT_WIDTH-1:0] v);
        return (&v) ? v : v + BIT_WIDTH'(1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;
    logic                   f;
    logic                   f_d;
    logic [BIT_WIDTH-1:0]   fc;
    logic [BIT_WIDTH-1:0]   fl_m1;
    logic                   rise;

    state_t               state;
    logic [BIT_WIDTH-1:0] wc;
    logic [BIT_WIDTH-1:0] hc;
    logic [BIT_WIDTH-1:0] min_l;
    logic [BIT_WIDTH-1:0] max_l;
    logic [BIT_WIDTH-1:0] hold_l;

    // Synchroniser stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], trig_in};
        end
    end

    assign s     = sync_p[SYNC_STAGES-1];
    assign fl_m1 = (filt_len == '0) ? '0 : filt_len - BIT_WIDTH'(1);
    assign rise  = f & ~f_d;

    // Glitch filter stage; >= keeps a live shrink of filt_len from running fc past its target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f   <= 1'b0;
            f_d <= 1'b0;
            fc  <= '0;
        end else begin
            f_d <= f;
            if (s == f) begin
                fc <= '0;
            end else if (fc >= fl_m1) begin
                f  <= s;
                fc <= '0;
            end else begin
                fc <= fc + BIT_WIDTH'(1);
            end
        end
    end

    // Width / hold-off FSM stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            drop       <= 1'b0;
            trig_count <= '0;
            wc         <= '0;
            hc         <= '0;
            min_l      <= '0;
            max_l      <= '0;
            hold_l     <= '0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            drop      <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        if (enable) begin
                            pulse_out  <= 1'b1;
                            busy       <= 1'b1;
                            wc         <= BIT_WIDTH'(1);
                            trig_count <= trig_count + BIT_WIDTH'(1);
                            min_l      <= min_width;
                            max_l      <= max_width;
                            hold_l     <= holdoff;
                            state      <= HIGH;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (max_l != '0 && wc == max_l) begin
                        pulse_out <= 1'b0;
                        err_long  <= 1'b1;
                        state     <= WAIT_LOW;
                    end else if (!f && wc >= min_l) begin
                        pulse_out <= 1'b0;
                        hc        <= BIT_WIDTH'(1);
                        state     <= HOLDOFF;
                    end else if (!f) begin
                        err_short <= 1'b1;
                        wc        <= sat_inc(wc);
                        state     <= STRETCH;
                    end else begin
                        wc <= sat_inc(wc);
                    end
                end
                STRETCH: begin
                    drop <= rise;
                    if (wc == min_l || (max_l != '0 && wc == max_l)) begin
                        pulse_out <= 1'b0;
                        hc        <= BIT_WIDTH'(1);
                        state     <= HOLDOFF;
                    end else begin
                        wc <= sat_inc(wc);
                    end
                end
                WAIT_LOW: begin
                    drop <= rise;
                    if (!f) begin
                        hc    <= BIT_WIDTH'(1);
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    drop <= rise;
                    if (hc >= hold_l) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hc <= sat_inc(hc);
                    end
                end
                default: begin
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
